// File: rtl/syscall_unit.sv
// -----------------------------------------------------------------------------
// syscall_unit
//
// Execute-stage responder for syscall instructions. When the decoder raises
// syscall_en, the unit reads the service code (syscall_v0) and the argument
// (syscall_a0) and performs the service:
//   10 -> halt            (sets the sticky halted flag)
//   34 -> print hex       (queues {kind=0, a0} toward the display)
//    1 -> print decimal   (queues {kind=1, a0} toward the display)
//   other -> unsupported  (sets the sticky bad_syscall flag)
// Print requests go through a small circular FIFO. The pipeline is stalled
// while a print is requested and that FIFO is full.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   syscall_en      : a valid syscall is in execute this cycle
//   syscall_v0      : service code (DATA_W)
//   syscall_a0      : service argument (DATA_W)
//   stall           : combinational pipeline hold request to the hazard unit
//   halted          : sticky, a halt service was accepted
//   done            : halted and the display FIFO has drained
//   bad_syscall     : sticky, an unsupported service code was accepted
//   syscall_count   : number of accepted syscalls (wraps, CNT_W bits)
//   disp_valid      : FIFO head is valid
//   disp_data       : FIFO head argument
//   disp_kind       : FIFO head format, 0 = hex, 1 = decimal
//   disp_ready      : display consumer takes the head this cycle
//
// Display handshake: the head entry transfers on a rising edge where
// disp_valid and disp_ready are both 1. While disp_valid is 1 and disp_ready
// is 0 the head (disp_data/disp_kind) is held unchanged. disp_valid never
// depends on disp_ready, and disp_data/disp_kind are don't-care while
// disp_valid is 0.
//
// FIFO_DEPTH must be a power of two and at least 2; the pointers rely on
// natural binary wrap from FIFO_DEPTH-1 to 0.
// -----------------------------------------------------------------------------
module syscall_unit #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              syscall_en,
    input  logic [DATA_W-1:0] syscall_v0,
    input  logic [DATA_W-1:0] syscall_a0,
    output logic              stall,
    output logic              halted,
    output logic              done,
    output logic              bad_syscall,
    output logic [CNT_W-1:0]  syscall_count,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_kind,
    input  logic              disp_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0]  OCC_FULL       = OCC_W'(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] CODE_PRINT_DEC = DATA_W'(1);
    localparam logic [DATA_W-1:0] CODE_HALT      = DATA_W'(10);
    localparam logic [DATA_W-1:0] CODE_PRINT_HEX = DATA_W'(34);

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic              kind_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occupancy;

    // Decode and control
    logic is_halt;
    logic is_print_dec;
    logic is_print_hex;
    logic is_print;
    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic push;
    logic pop;

    always_comb begin
        is_halt      = (syscall_v0 == CODE_HALT);
        is_print_dec = (syscall_v0 == CODE_PRINT_DEC);
        is_print_hex = (syscall_v0 == CODE_PRINT_HEX);
        is_print     = is_print_dec | is_print_hex;

        // Full/empty come from the registered occupancy only. A pop in the
        // same cycle does not release the stall; the syscall is accepted in
        // the cycle after the pop instead. This keeps stall off the
        // disp_ready path.
        fifo_full  = (occupancy == OCC_FULL);
        fifo_empty = (occupancy == '0);

        stall  = syscall_en & ~halted & is_print & fifo_full;
        accept = syscall_en & ~halted & ~stall;
        push   = accept & is_print;
        pop    = ~fifo_empty & disp_ready;

        disp_valid = ~fifo_empty;
        disp_data  = data_mem[rd_ptr];
        disp_kind  = kind_mem[rd_ptr];
        done       = halted & fifo_empty;
    end

    // Status flags and the accepted-syscall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            halted        <= 1'b0;
            bad_syscall   <= 1'b0;
            syscall_count <= '0;
        end else if (accept) begin
            syscall_count <= syscall_count + CNT_W'(1);
            if (is_halt) begin
                halted <= 1'b1;
            end
            if (!is_halt && !is_print) begin
                bad_syscall <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy. Push on full cannot happen because stall
    // blocks acceptance, so push+pop together always leaves occupancy as is.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // FIFO storage. Cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                kind_mem[i] <= 1'b0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= syscall_a0;
            kind_mem[wr_ptr] <= is_print_dec;
        end
    end

endmodule

// File: doc/syscall_unit.md
# syscall_unit

Responder for the `syscall_en` request raised by the instruction decoder: when a syscall reaches execute, this block reads the service code ($v0) and argument ($a0), then performs the service. Supported services are halt, print hex and print decimal; any other code is flagged as unsupported. Print requests are buffered in a small FIFO toward the display/console logic, and the pipeline is stalled while that FIFO is full. The block sits beside the ALU in the execute stage and feeds the hazard unit (`stall`) and the board display driver (`disp_*`).

## Interface

Clocking and reset (already decided): one clock; reset is synchronous and active-high.

**Parameters**
- `DATA_W`, default 32: register and argument width.
- `FIFO_DEPTH`, default 4: display FIFO entries. Must be a power of two, ≥2.
- `CNT_W`, default 32: syscall counter width.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `syscall_en`, in, 1: a valid syscall instruction is in execute this cycle.
- `syscall_v0`, in, DATA_W: service code (regfile port A during a syscall).
- `syscall_a0`, in, DATA_W: argument (regfile port B during a syscall).
- `stall`, out, 1: combinational; holds the pipeline, so `syscall_en` and the operands are held stable.
- `halted`, out, 1: sticky; a halt service was accepted.
- `done`, out, 1: `halted` and FIFO empty (bench/board stop condition).
- `bad_syscall`, out, 1: sticky; an unsupported service code was accepted.
- `syscall_count`, out, CNT_W: number of accepted syscalls.
- `disp_valid`, out, 1: FIFO head is valid.
- `disp_data`, out, DATA_W: FIFO head argument.
- `disp_kind`, out, 1: FIFO head format; 0 = hex, 1 = decimal.
- `disp_ready`, in, 1: consumer accepts the head this cycle.

## Operation

**Service codes** (full 32-bit compare on `syscall_v0`)
- 10: halt.
- 34: print hex.
- 1: print decimal.
- Any other value: unsupported.

**Acceptance rule.** A syscall is accepted in a cycle with `syscall_en`=1, `halted`=0 and `stall`=0.

**Stall**
- `stall` = `syscall_en` & !`halted` & (code is 1 or 34) & `fifo_full`.
- `fifo_full` comes from registered occupancy only. A pop in the same cycle does not clear the stall; there is no bypass.

**On acceptance**
- Halt: `halted` ← 1.
- Print: push {`kind`, `syscall_a0`} into the FIFO. `kind` = 1 for code 1, 0 for code 34.
- Unsupported: `bad_syscall` ← 1.
- In every case `syscall_count` increments by 1. It increments once per accepted syscall, not once per stall cycle, and wraps modulo 2^CNT_W.

**After halt**
- `syscall_en` is ignored: no stall, no count, no push, no flag change.
- The FIFO continues to drain. `halted` clears only on `rst`.

**FIFO**
- Circular buffer with read/write pointers of width log2(FIFO_DEPTH) and an occupancy counter of width log2(FIFO_DEPTH)+1.
- Pointers wrap from FIFO_DEPTH-1 to 0.
- Pop when `disp_valid` & `disp_ready`.
- Push and pop in the same cycle: occupancy unchanged, both pointers advance. This can only occur when the FIFO is not full.
- Pop on empty is ignored, and `disp_data`/`disp_kind` are don't-care while `disp_valid`=0.
- Push on full cannot occur, because `stall` blocks it.

**Reset values**
- `halted`, `bad_syscall`, `syscall_count`: 0.
- FIFO empty, with `disp_valid`=0.
- `done`=0; `stall` follows its combinational inputs.
- `disp_data`=0 and `disp_kind`=0, with storage cleared.
- Reset in the middle of a stall or drain discards all FIFO contents.

## Timing

- A push accepted in cycle N appears at the head (`disp_valid`=1) in cycle N+1 if the FIFO was empty.
- `halted`, `bad_syscall` and `syscall_count` update at the edge ending the accepting cycle, so they are visible in N+1.
- `stall` is asserted in the same cycle as the blocked `syscall_en`. It drops in the cycle after a pop makes room; the syscall is accepted in that cycle.
- `done` rises in the cycle after the last pop, or in N+1 after a halt if the FIFO was already empty.
- The head is stable while `disp_valid`=1 and `disp_ready`=0.

## Test plan

1. **Print hex.** `rst`, then a syscall with v0=34, a0=0xDEADBEEF, `disp_ready`=1.
   Required: next cycle `disp_valid`=1, `disp_data`=0xDEADBEEF, `disp_kind`=0, `syscall_count`=1; FIFO empty one cycle later.
2. **Fill and stall.** `disp_ready`=0; five consecutive print syscalls with v0=1, a0=1..5 (depth 4).
   Required: first four accepted; on the fifth, `stall`=1 and `syscall_count`=4. Raise `disp_ready` for one cycle: `stall` drops in the following cycle and the count becomes 5. The drain order is 1,2,3,4,5, all with `disp_kind`=1.
3. **Halt while buffered.** Two pending prints, then v0=10.
   Required: `halted`=1 in the next cycle and `done`=0 until both entries pop, then `done`=1. A later syscall with v0=34 causes no stall, no count change and no push.
4. **Unsupported code.** v0=0x0000FFFF.
   Required: `bad_syscall`=1 (sticky), count increments, no push, no halt.
5. **Simultaneous push and pop, and wrap.** One entry held, `disp_ready`=1, a new print accepted in the same cycle; repeat 10 times.
   Required: occupancy stays 1, data is in order across pointer wrap, and `stall` is never asserted.
6. **Reset during a stall.** FIFO full, `stall`=1, assert `rst` for one cycle.
   Required: next cycle `disp_valid`=0, count 0, flags 0. `stall` is still combinationally 0 because the FIFO is empty, so the pending syscall is accepted.
